multicycle_main_control: RTL and testbench
==========================================

Name: multicycle_main_control

Overview:
- Multi-cycle main control FSM for the RV32I subset core: R-type ALU ops, lw, sw, beq.
- Sequences fetch, decode, execute, memory and writeback. Drives all datapath enables plus the 2-bit ALUop consumed by the ALU control decoder (00 add, 01 sub/compare, 10 decode funct3/funct7).
- Sits between the instruction register opcode field and the shared unified memory port, which uses a req/ready wait handshake.

Parameters:
- TRAP_RECOVER, 0: 0 = TRAP state is terminal until reset; 1 = TRAP returns to FETCH after one cycle.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  instr[6:0] from instruction register
- mem_ready  in  1  memory completes the current read/write this cycle
- ALUop  out  2  to ALU control decoder
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load qualified by ALU zero (datapath ANDs)
- PCSource  out  1  0 = ALU result, 1 = ALUOut register
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  load instruction register
- RegWrite  out  1  register file write
- MemtoReg  out  1  writeback: 0 = ALUOut, 1 = MDR
- ALUSrcA  out  1  0 = PC, 1 = rs1 register
- ALUSrcB  out  2  00 rs2, 01 const 4, 10 imm (I/S), 11 imm (B)
- instr_done  out  1  one-cycle pulse in the last cycle of each instruction
- illegal  out  1  high while in TRAP

Behaviour:
- States: IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, WB_MEM, MEM_WR, EXEC_R, WB_R, EXEC_BR, TRAP.
- rst_n low, at any time including mid-instruction: state = IDLE immediately.
  - All outputs 0, ALUop = 00.
  - Any in-flight memory request is dropped.
- IDLE -> FETCH unconditionally, one cycle after reset release.
- All outputs are decoded from state only, except IRWrite/PCWrite in FETCH and instr_done, which are qualified by mem_ready. Unlisted outputs are 0.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=00, PCSource=0.
  - IRWrite = PCWrite = mem_ready.
  - Stay while mem_ready=0; -> DECODE when mem_ready=1.
- DECODE (computes branch target into ALUOut): ALUSrcA=0, ALUSrcB=11, ALUop=00. opcode is sampled here only:
  - 0110011 -> EXEC_R
  - 0000011 or 0100011 -> MEM_ADDR
  - 1100011 -> EXEC_BR
  - any other -> TRAP
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUop=00. -> MEM_RD if opcode is lw, else MEM_WR. The opcode is held stable by the IR.
- MEM_RD: MemRead=1, IorD=1. Wait for mem_ready, then -> WB_MEM.
- WB_MEM: RegWrite=1, MemtoReg=1, instr_done=1. -> FETCH.
- MEM_WR: MemWrite=1, IorD=1. Wait for mem_ready; instr_done = mem_ready. -> FETCH on mem_ready.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUop=10. -> WB_R.
- WB_R: RegWrite=1, MemtoReg=0, instr_done=1. -> FETCH.
- EXEC_BR: ALUSrcA=1, ALUSrcB=00, ALUop=01, PCWriteCond=1, PCSource=1, instr_done=1. -> FETCH.
- TRAP: illegal=1, all else 0.
  - TRAP_RECOVER=0: stay in TRAP.
  - TRAP_RECOVER=1: -> FETCH next cycle. The faulting instruction is skipped because PC was already advanced in FETCH.
- mem_ready is ignored in states without an outstanding request.
- Memory request outputs (MemRead, MemWrite, IorD) stay constant while waiting.
- Minimum latency with zero wait states: beq 3 cycles, R-type 4, sw 4, lw 5. Each memory wait cycle adds 1.
- No combinational path from opcode to any output.

Optional Feature:
- Macro: MAIN_CTRL_RETIRE_CNT_EN.
- Defined:
  - Adds output retire_cnt [31:0], reset to 0.
  - Increments by 1 on every cycle with instr_done=1 and wraps from 0xFFFFFFFF to 0.
  - Does not count TRAP.
- Undefined: no port, no counter logic. FSM behaviour is identical either way.

Test Plan:
- Reset: rst_n=0 for 3 cycles -> all outputs 0. After release: IDLE for 1 cycle, then FETCH with MemRead=1, ALUSrcB=01.
- R-type: opcode=0110011, mem_ready=1 always -> states FETCH, DECODE, EXEC_R (ALUop=10), WB_R (RegWrite=1, instr_done=1). Next FETCH at cycle 5.
- lw with 2 wait cycles each on fetch and read: opcode=0000011 -> FETCH held 3 cycles with IRWrite=0,0,1. MEM_RD held 3 cycles with IorD=1. WB_MEM with MemtoReg=1. Total 9 cycles.
- sw then beq: opcode 0100011 -> MemWrite=1 for exactly 1 cycle with mem_ready=1. Then opcode 1100011 -> EXEC_BR with ALUop=01, PCWriteCond=1, PCSource=1. beq totals 3 cycles.
- Illegal opcode 1111111:
  - TRAP_RECOVER=0 -> illegal stays 1 for 20 cycles, no MemRead.
  - TRAP_RECOVER=1 -> illegal for 1 cycle, then FETCH.
- Reset mid-MEM_RD (mem_ready=0): assert rst_n=0 -> outputs 0 in the same cycle (async). Subsequent mem_ready=1 is ignored. Restart goes IDLE -> FETCH. With MAIN_CTRL_RETIRE_CNT_EN defined, retire_cnt=0.

Source files
------------

// File: rtl/multicycle_main_control_if.sv
// Control bundle between the main control FSM, the instruction register and the datapath.
// The master side is the controller; the slave side is the datapath and memory port.
interface multicycle_main_control_if;
  logic [6:0] opcode;
  logic       mem_ready;
  logic [1:0] ALUop;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       PCSource;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic       MemtoReg;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       instr_done;
  logic       illegal;

  modport master (
    input  opcode, mem_ready,
    output ALUop, PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite,
           IRWrite, RegWrite, MemtoReg, ALUSrcA, ALUSrcB, instr_done, illegal
  );

  modport slave (
    output opcode, mem_ready,
    input  ALUop, PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite,
           IRWrite, RegWrite, MemtoReg, ALUSrcA, ALUSrcB, instr_done, illegal
  );
endinterface

// File: rtl/multicycle_main_control.sv
// Multi-cycle main control FSM for the RV32I subset core (R-type, lw, sw, beq).
// Optional retired-instruction counter enabled by defining MAIN_CTRL_RETIRE_CNT_EN.
module multicycle_main_control #(
  parameter bit TRAP_RECOVER = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  multicycle_main_control_if.master bus
`ifdef MAIN_CTRL_RETIRE_CNT_EN
  ,
  output logic [31:0]               retire_cnt
`endif
);

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    DECODE,
    MEM_ADDR,
    MEM_RD,
    WB_MEM,
    MEM_WR,
    EXEC_R,
    WB_R,
    EXEC_BR,
    TRAP
  } state_t;

  state_t state;
  state_t next_state;

  logic [1:0] alu_op;
  logic       pc_write;
  logic       pc_write_cond;
  logic       pc_source;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       done;
  logic       trap_flag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Outputs depend on state only (plus mem_ready qualifiers), so opcode never reaches an output.
  always_comb begin
    next_state    = state;
    alu_op        = 2'b00;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    done          = 1'b0;
    trap_flag     = 1'b0;

    case (state)
      IDLE: begin
        next_state = FETCH;
      end
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = bus.mem_ready;
        pc_write  = bus.mem_ready;
        if (bus.mem_ready) begin
          next_state = DECODE;
        end
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (bus.opcode)
          OP_RTYPE:           next_state = EXEC_R;
          OP_LOAD, OP_STORE:  next_state = MEM_ADDR;
          OP_BRANCH:          next_state = EXEC_BR;
          default:            next_state = TRAP;
        endcase
      end
      MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        next_state = (bus.opcode == OP_LOAD) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (bus.mem_ready) begin
          next_state = WB_MEM;
        end
      end
      WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        done       = 1'b1;
        next_state = FETCH;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        done      = bus.mem_ready;
        if (bus.mem_ready) begin
          next_state = FETCH;
        end
      end
      EXEC_R: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b10;
        next_state = WB_R;
      end
      WB_R: begin
        reg_write  = 1'b1;
        done       = 1'b1;
        next_state = FETCH;
      end
      EXEC_BR: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 1'b1;
        done          = 1'b1;
        next_state    = FETCH;
      end
      TRAP: begin
        trap_flag  = 1'b1;
        next_state = TRAP_RECOVER ? FETCH : TRAP;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign bus.ALUop       = alu_op;
  assign bus.PCWrite     = pc_write;
  assign bus.PCWriteCond = pc_write_cond;
  assign bus.PCSource    = pc_source;
  assign bus.IorD        = iord;
  assign bus.MemRead     = mem_read;
  assign bus.MemWrite    = mem_write;
  assign bus.IRWrite     = ir_write;
  assign bus.RegWrite    = reg_write;
  assign bus.MemtoReg    = mem_to_reg;
  assign bus.ALUSrcA     = alu_src_a;
  assign bus.ALUSrcB     = alu_src_b;
  assign bus.instr_done  = done;
  assign bus.illegal     = trap_flag;

`ifdef MAIN_CTRL_RETIRE_CNT_EN
  // TRAP never raises done, so faulting instructions are not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt <= 32'd0;
    end else if (done) begin
      retire_cnt <= retire_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed bench for multicycle_main_control: a TRAP_RECOVER=0 and a TRAP_RECOVER=1 instance
// share one stimulus; outputs are packed into a 16-bit vector and compared to hand-built constants.
module tb_multicycle_main_control;

  // Vector layout: [15:14] ALUop, 13 PCWrite, 12 PCWriteCond, 11 PCSource, 10 IorD, 9 MemRead,
  // 8 MemWrite, 7 IRWrite, 6 RegWrite, 5 MemtoReg, 4 ALUSrcA, [3:2] ALUSrcB, 1 instr_done, 0 illegal
  localparam logic [15:0] V_ZERO     = 16'h0000;
  localparam logic [15:0] V_FETCH_W  = 16'h0204;
  localparam logic [15:0] V_FETCH_R  = 16'h2284;
  localparam logic [15:0] V_DECODE   = 16'h000C;
  localparam logic [15:0] V_MEM_ADDR = 16'h0018;
  localparam logic [15:0] V_MEM_RD   = 16'h0600;
  localparam logic [15:0] V_WB_MEM   = 16'h0062;
  localparam logic [15:0] V_MEM_WR_R = 16'h0502;
  localparam logic [15:0] V_EXEC_R   = 16'h8010;
  localparam logic [15:0] V_WB_R     = 16'h0042;
  localparam logic [15:0] V_EXEC_BR  = 16'h5812;
  localparam logic [15:0] V_TRAP     = 16'h0001;

  logic       clk;
  logic       rst_n;
  logic [6:0] opcode;
  logic       mem_ready;
  int         tests_run;
  int         tests_failed;

  multicycle_main_control_if bus_a ();
  multicycle_main_control_if bus_b ();

  assign bus_a.opcode    = opcode;
  assign bus_a.mem_ready = mem_ready;
  assign bus_b.opcode    = opcode;
  assign bus_b.mem_ready = mem_ready;

`ifdef MAIN_CTRL_RETIRE_CNT_EN
  logic [31:0] retire_a;
  logic [31:0] retire_b;
`endif

  multicycle_main_control #(.TRAP_RECOVER(1'b0)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.master)
`ifdef MAIN_CTRL_RETIRE_CNT_EN
    ,
    .retire_cnt (retire_a)
`endif
  );

  multicycle_main_control #(.TRAP_RECOVER(1'b1)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.master)
`ifdef MAIN_CTRL_RETIRE_CNT_EN
    ,
    .retire_cnt (retire_b)
`endif
  );

  logic [15:0] vec_a;
  logic [15:0] vec_b;

  assign vec_a = {bus_a.ALUop, bus_a.PCWrite, bus_a.PCWriteCond, bus_a.PCSource, bus_a.IorD,
                  bus_a.MemRead, bus_a.MemWrite, bus_a.IRWrite, bus_a.RegWrite, bus_a.MemtoReg,
                  bus_a.ALUSrcA, bus_a.ALUSrcB, bus_a.instr_done, bus_a.illegal};
  assign vec_b = {bus_b.ALUop, bus_b.PCWrite, bus_b.PCWriteCond, bus_b.PCSource, bus_b.IorD,
                  bus_b.MemRead, bus_b.MemWrite, bus_b.IRWrite, bus_b.RegWrite, bus_b.MemtoReg,
                  bus_b.ALUSrcA, bus_b.ALUSrcB, bus_b.instr_done, bus_b.illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle, then drive mem_ready for that cycle and let the outputs settle.
  task automatic step(input logic mr);
    @(posedge clk);
    #1;
    mem_ready = mr;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    tests_run++;
    if (vec_a !== V_ZERO) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got %h expected %h", vec_a, V_ZERO);
    end
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (vec_a !== V_ZERO) begin
      tests_failed++;
      $display("[TB] FAIL reset_idle: got %h expected %h", vec_a, V_ZERO);
    end
    step(1'b0);
    tests_run++;
    if (vec_a !== V_FETCH_W) begin
      tests_failed++;
      $display("[TB] FAIL reset_fetch: got %h expected %h", vec_a, V_FETCH_W);
    end
  endtask

  task automatic test_rtype();
    logic [15:0] exp_vec [4];
    exp_vec = '{V_FETCH_R, V_DECODE, V_EXEC_R, V_WB_R};
    opcode = 7'b0110011;
    for (int i = 0; i < 4; i++) begin
      step(1'b1);
      tests_run++;
      if (vec_a !== exp_vec[i]) begin
        tests_failed++;
        $display("[TB] FAIL rtype cycle %0d: got %h expected %h", i, vec_a, exp_vec[i]);
      end
    end
  endtask

  task automatic test_lw_waits();
    logic [15:0] exp_vec [9];
    logic        mr_vec  [9];
    exp_vec = '{V_FETCH_W, V_FETCH_W, V_FETCH_R, V_DECODE, V_MEM_ADDR,
                V_MEM_RD, V_MEM_RD, V_MEM_RD, V_WB_MEM};
    mr_vec  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    opcode = 7'b0000011;
    for (int i = 0; i < 9; i++) begin
      step(mr_vec[i]);
      tests_run++;
      if (vec_a !== exp_vec[i]) begin
        tests_failed++;
        $display("[TB] FAIL lw_waits cycle %0d: got %h expected %h", i, vec_a, exp_vec[i]);
      end
    end
  endtask

  task automatic test_sw_beq();
    logic [15:0] exp_vec [7];
    exp_vec = '{V_FETCH_R, V_DECODE, V_MEM_ADDR, V_MEM_WR_R, V_FETCH_R, V_DECODE, V_EXEC_BR};
    opcode = 7'b0100011;
    for (int i = 0; i < 7; i++) begin
      step(1'b1);
      tests_run++;
      if (vec_a !== exp_vec[i]) begin
        tests_failed++;
        $display("[TB] FAIL sw_beq cycle %0d: got %h expected %h", i, vec_a, exp_vec[i]);
      end
      if (i == 3) begin
        opcode = 7'b1100011;
      end
    end
  endtask

  task automatic test_illegal();
    opcode = 7'b1111111;
    step(1'b1);
    step(1'b1);
    step(1'b0);
    tests_run++;
    if (vec_a !== V_TRAP || vec_b !== V_TRAP) begin
      tests_failed++;
      $display("[TB] FAIL trap_entry: got a=%h b=%h expected %h", vec_a, vec_b, V_TRAP);
    end
    step(1'b0);
    tests_run++;
    if (vec_b !== V_FETCH_W) begin
      tests_failed++;
      $display("[TB] FAIL trap_recover_fetch: got %h expected %h", vec_b, V_FETCH_W);
    end
    for (int i = 0; i < 20; i++) begin
      tests_run++;
      if (vec_a !== V_TRAP) begin
        tests_failed++;
        $display("[TB] FAIL trap_hold cycle %0d: got %h expected %h", i, vec_a, V_TRAP);
      end
      step(1'b0);
    end
`ifdef MAIN_CTRL_RETIRE_CNT_EN
    tests_run++;
    if (retire_a !== 32'd4) begin
      tests_failed++;
      $display("[TB] FAIL retire_count: got %0d expected 4", retire_a);
    end
`endif
  endtask

  task automatic test_reset_mid_read();
    logic [15:0] exp_vec [4];
    exp_vec = '{V_FETCH_R, V_DECODE, V_MEM_ADDR, V_MEM_RD};
    rst_n = 1'b0;
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0);
    tests_run++;
    if (vec_a !== V_FETCH_W) begin
      tests_failed++;
      $display("[TB] FAIL restart_fetch: got %h expected %h", vec_a, V_FETCH_W);
    end
    opcode = 7'b0000011;
    for (int i = 0; i < 4; i++) begin
      step(i < 3 ? 1'b1 : 1'b0);
      tests_run++;
      if (vec_a !== exp_vec[i]) begin
        tests_failed++;
        $display("[TB] FAIL mid_read cycle %0d: got %h expected %h", i, vec_a, exp_vec[i]);
      end
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (vec_a !== V_ZERO) begin
      tests_failed++;
      $display("[TB] FAIL async_reset: got %h expected %h", vec_a, V_ZERO);
    end
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    tests_run++;
    if (vec_a !== V_ZERO) begin
      tests_failed++;
      $display("[TB] FAIL reset_ignores_ready: got %h expected %h", vec_a, V_ZERO);
    end
`ifdef MAIN_CTRL_RETIRE_CNT_EN
    tests_run++;
    if (retire_a !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL retire_reset: got %0d expected 0", retire_a);
    end
`endif
    mem_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (vec_a !== V_ZERO) begin
      tests_failed++;
      $display("[TB] FAIL restart_idle: got %h expected %h", vec_a, V_ZERO);
    end
    step(1'b0);
    tests_run++;
    if (vec_a !== V_FETCH_W) begin
      tests_failed++;
      $display("[TB] FAIL restart_fetch2: got %h expected %h", vec_a, V_FETCH_W);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    opcode       = 7'b0000000;
    mem_ready    = 1'b0;
    test_reset();
    test_rtype();
    test_lw_waits();
    test_sw_beq();
    test_illegal();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
